// File: rtl/seg7_pkg.sv
// Shared types and constants for the four-digit multiplexed seven-segment scanner.
package seg7_pkg;

    localparam int unsigned DATA_W  = 16;
    localparam int unsigned NIB_W   = 4;
    localparam int unsigned SEG_W   = 7;
    localparam int unsigned AN_W    = 4;
    localparam int unsigned DIG_W   = 2;
    localparam int unsigned HEX_CNT = 16;

    typedef enum logic {
        GAP   = 1'b0,
        DRIVE = 1'b1
    } state_t;

    localparam logic [SEG_W-1:0] SEG_BLANK = 7'b1111111;
    localparam logic [AN_W-1:0]  AN_OFF    = 4'b1111;

    // Active-low {g,f,e,d,c,b,a}; entry k is the glyph for hex digit k.
    localparam logic [HEX_CNT-1:0][SEG_W-1:0] HEX_SEG = {
        7'b0001110,  // F
        7'b0000110,  // E
        7'b0100001,  // d
        7'b1000110,  // C
        7'b0000011,  // b
        7'b0001000,  // A
        7'b0010000,  // 9
        7'b0000000,  // 8
        7'b1111000,  // 7
        7'b0000010,  // 6
        7'b0010010,  // 5
        7'b0011001,  // 4
        7'b0110000,  // 3
        7'b0100100,  // 2
        7'b1111001,  // 1
        7'b1000000   // 0
    };

    // Active-low one-hot anode pattern for a digit index.
    function automatic logic [AN_W-1:0] an_select(input logic [DIG_W-1:0] dig);
        return ~(AN_W'(1) << dig);
    endfunction

endpackage

// File: rtl/seg7_if.sv
// Processor-side value/blanking inputs and panel-side segment/anode/dp drive.
interface seg7_if;
    import seg7_pkg::*;

    logic [DATA_W-1:0] DATA;
    logic              BLANK_LZ;
    logic [SEG_W-1:0]  SEG;
    logic [AN_W-1:0]   AN;
    logic              DP;

    modport master (
        output DATA,
        output BLANK_LZ,
        input  SEG,
        input  AN,
        input  DP
    );

    modport slave (
        input  DATA,
        input  BLANK_LZ,
        output SEG,
        output AN,
        output DP
    );
endinterface

// File: rtl/hex7seg.sv
// Combinational hex nibble to active-low seven-segment glyph.
module hex7seg
    import seg7_pkg::*;
(
    input  logic [NIB_W-1:0] nibble,
    output logic [SEG_W-1:0] seg
);

    assign seg = HEX_SEG[nibble];

endmodule

// File: rtl/seg7_scan.sv
// Four-digit multiplexed display scanner: prescaler, GAP/DRIVE slot FSM,
// frame-aligned shadow of the input value, leading-zero blanking, registered drive.
module seg7_scan
    import seg7_pkg::*;
#(
    parameter int unsigned CLK_DIV = 50000,  // cycles per digit slot, >= 4
    parameter int unsigned GAP_CYC = 500     // blanking cycles at slot start, 1..CLK_DIV-1
) (
    input  logic  ClK,
    input  logic  RESET,
    seg7_if.slave bus
);

    localparam int unsigned          CNT_W        = $clog2(CLK_DIV);
    localparam logic [CNT_W-1:0]     CNT_LAST     = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0]     CNT_GAP_LAST = CNT_W'(GAP_CYC - 1);
    localparam logic [DIG_W-1:0]     DIG_LAST     = DIG_W'(AN_W - 1);

    logic [CNT_W-1:0]  cnt;
    logic [DIG_W-1:0]  dig;
    logic              slot_end;
    logic              frame_end;

    state_t            state;
    state_t            state_nxt;

    logic [DATA_W-1:0] shd;
    logic              lz_en;

    logic [NIB_W-1:0]  cur_nib;
    logic [SEG_W-1:0]  cur_glyph;
    logic              dig_blank;

    logic [SEG_W-1:0]  seg_nxt;
    logic [AN_W-1:0]   an_nxt;

    assign slot_end  = (cnt == CNT_LAST);
    assign frame_end = slot_end && (dig == DIG_LAST);

    // Slot prescaler and digit index; the 2-bit index wraps 3 -> 0 on its own.
    always_ff @(posedge ClK or negedge RESET) begin
        if (!RESET) begin
            cnt <= '0;
            dig <= '0;
        end else begin
            cnt <= slot_end ? '0 : cnt + CNT_W'(1);
            if (slot_end) begin
                dig <= dig + DIG_W'(1);
            end
        end
    end

    // Value is captured only at the frame boundary so a frame never tears
    // and short input pulses between boundaries are not seen at all.
    always_ff @(posedge ClK or negedge RESET) begin
        if (!RESET) begin
            shd   <= '0;
            lz_en <= 1'b0;
        end else if (frame_end) begin
            shd   <= bus.DATA;
            lz_en <= bus.BLANK_LZ;
        end
    end

    assign cur_nib = NIB_W'(shd >> {dig, 2'b00});

    hex7seg u_hex7seg (
        .nibble (cur_nib),
        .seg    (cur_glyph)
    );

    // Leading-zero suppression looks at the current digit and everything above it.
    always_comb begin
        dig_blank = 1'b0;
        case (dig)
            2'd3:    dig_blank = lz_en && (shd[15:12] == 4'h0);
            2'd2:    dig_blank = lz_en && (shd[15:8]  == 8'h00);
            2'd1:    dig_blank = lz_en && (shd[15:4]  == 12'h000);
            default: dig_blank = 1'b0;
        endcase
    end

    always_ff @(posedge ClK or negedge RESET) begin
        if (!RESET) begin
            state <= GAP;
        end else begin
            state <= state_nxt;
        end
    end

    // The GAP exit is taken on GAP_CYC-1 so that state reads DRIVE exactly
    // when cnt == GAP_CYC, keeping state equivalent to (cnt >= GAP_CYC).
    always_comb begin
        state_nxt = state;
        an_nxt    = AN_OFF;
        seg_nxt   = SEG_BLANK;
        case (state)
            GAP: begin
                if (cnt == CNT_GAP_LAST) begin
                    state_nxt = DRIVE;
                end
            end
            DRIVE: begin
                an_nxt  = an_select(dig);
                seg_nxt = dig_blank ? SEG_BLANK : cur_glyph;
                if (slot_end) begin
                    state_nxt = GAP;
                end
            end
            default: begin
                state_nxt = GAP;
            end
        endcase
    end

    // Panel drive registers: one cycle behind the FSM/prescaler state.
    always_ff @(posedge ClK or negedge RESET) begin
        if (!RESET) begin
            bus.SEG <= SEG_BLANK;
            bus.AN  <= AN_OFF;
            bus.DP  <= 1'b1;
        end else begin
            bus.SEG <= seg_nxt;
            bus.AN  <= an_nxt;
            bus.DP  <= 1'b1;
        end
    end

endmodule

// File: tb/tb_seg7_scan.sv
// Randomized scoreboard bench for seg7_scan with a frame-level display model.
module tb_seg7_scan;

    localparam int D     = 8;
    localparam int G     = 2;
    localparam int FRAME = 4 * D;

    localparam logic [6:0] HEX [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
    } disp_t;

    logic ClK   = 1'b0;
    logic RESET = 1'b0;

    seg7_if bus ();

    seg7_scan #(
        .CLK_DIV (D),
        .GAP_CYC (G)
    ) dut (
        .ClK   (ClK),
        .RESET (RESET),
        .bus   (bus)
    );

    initial forever #5 ClK = ~ClK;

    disp_t       exp_q[$];
    int          cyc      = 0;
    logic [15:0] m_val    = 16'h0000;
    logic        m_lz     = 1'b0;
    int          n_vec    = 0;
    int          n_fail   = 0;
    int          tmo_req  = 0;
    int          tmo_seen = 0;

    // What the panel should show during frame position p for a latched value/lz.
    function automatic disp_t ref_disp(input int p, input logic [15:0] v, input logic lz);
        disp_t r;
        int    digit;
        int    nib;
        logic [15:0] upper;
        digit = p / D;
        r.an  = 4'hF;
        r.seg = 7'h7F;
        if ((p % D) >= G) begin
            r.an[digit] = 1'b0;
            upper = v >> (4 * digit);
            nib   = int'(upper & 16'h000F);
            if (!(lz && digit > 0 && upper == 16'h0000)) begin
                r.seg = HEX[nib];
            end
        end
        return r;
    endfunction

    task automatic cmp_disp(input string name, input logic [11:0] act, input logic [11:0] want);
        n_vec++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got an=%b seg=%b dp=%b, want an=%b seg=%b dp=%b",
                     name, cyc, act[11:8], act[7:1], act[0], want[11:8], want[7:1], want[0]);
        end
    endtask

    task automatic cmp_int(input string name, input int act, input int want);
        n_vec++;
        if (act != want) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %0d, want %0d", name, cyc, act, want);
        end
    endtask

    // Reference model: one expected panel state per clock edge since reset release.
    initial forever begin
        int p;
        @(posedge ClK or negedge RESET);
        if (!RESET) begin
            cyc   = 0;
            m_val = 16'h0000;
            m_lz  = 1'b0;
        end else begin
            p = cyc % FRAME;
            exp_q.push_back(ref_disp(p, m_val, m_lz));
            if (p == FRAME - 1) begin
                m_val = bus.DATA;
                m_lz  = bus.BLANK_LZ;
            end
            cyc++;
        end
    end

    // Monitor: compares panel outputs against the queue and measures anode windows.
    initial begin
        disp_t      e;
        int         lo_run = 0;
        int         hi_run = 0;
        logic [3:0] an_s;
        forever begin
            @(negedge ClK or negedge RESET);
            if (tmo_req != tmo_seen) begin
                tmo_seen = tmo_req;
                n_vec++;
                n_fail++;
                $display("FAIL wait_timeout @cyc %0d: got no match, want frame position reached", cyc);
            end
            if (!RESET) begin
                exp_q.delete();
                lo_run = 0;
                hi_run = 0;
                #1;
                cmp_disp("reset_out", {bus.AN, bus.SEG, bus.DP}, {4'b1111, 7'b1111111, 1'b1});
            end else if (exp_q.size() > 0) begin
                e    = exp_q.pop_front();
                an_s = bus.AN;
                cmp_disp("scan", {an_s, bus.SEG, bus.DP}, {e.an, e.seg, 1'b1});
                if (an_s == 4'hF) begin
                    if (lo_run > 0) begin
                        cmp_int("window_len", lo_run, D - G);
                        lo_run = 0;
                        hi_run = 0;
                    end
                    hi_run++;
                end else begin
                    if (lo_run == 0) begin
                        cmp_int("gap_len", hi_run, G);
                    end
                    cmp_int("anode_onehot", $countones(~an_s), 1);
                    lo_run++;
                end
            end
        end
    end

    // Wait (bounded) until the cycle in progress is frame position p.
    task automatic wait_pos(input int p);
        for (int i = 0; i < 2 * FRAME; i++) begin
            @(negedge ClK);
            if ((cyc % FRAME) == p) return;
        end
        tmo_req++;
    endtask

    task automatic run(input int n);
        repeat (n) @(negedge ClK);
    endtask

    initial begin
        logic [15:0] v;
        bus.DATA     = 16'h12AF;
        bus.BLANK_LZ = 1'b0;
        RESET        = 1'b0;

        // Power-up: first frame shows 0000, the second shows 12AF.
        run(3);
        RESET = 1'b1;
        run(2 * FRAME);

        // Tearing: change mid digit-1 slot of a frame showing 1111.
        bus.DATA = 16'h1111;
        wait_pos(0);
        wait_pos(D + 4);
        bus.DATA = 16'h2222;
        run(2 * FRAME);

        // Leading-zero blanking.
        bus.DATA     = 16'h0040;
        bus.BLANK_LZ = 1'b1;
        run(2 * FRAME + 5);

        // Random values and hold times, including pulses too short to reach a boundary.
        for (int i = 0; i < 24; i++) begin
            v            = 16'($urandom);
            v            = v >> (4 * $urandom_range(0, 3));
            bus.DATA     = v;
            bus.BLANK_LZ = 1'($urandom_range(0, 1));
            run($urandom_range(1, 40));
        end

        // Asynchronous reset during digit 2 DRIVE; shadow must restart at 0.
        bus.DATA     = 16'hBEEF;
        bus.BLANK_LZ = 1'b0;
        wait_pos(0);
        wait_pos(2 * D + 4);
        #2;
        RESET = 1'b0;
        run(3);
        RESET = 1'b1;
        run(FRAME + 4);

        // Ten frames of scanning with data churning underneath.
        for (int i = 0; i < 20; i++) begin
            bus.DATA     = 16'($urandom);
            bus.BLANK_LZ = 1'($urandom_range(0, 1));
            run(FRAME / 2);
        end

        run(4);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
